// File: rtl/qspis_wb_pkg.sv
// Shared types and helpers for the QSPI slave register-to-Wishbone bridge.
package qspis_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Read data handed back when the slave errors or never answers.
    localparam logic [31:0] TO_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // Number of byte lanes for a given data width.
    function automatic int beWidth(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/qspis_wb_tmr.sv
// Wait-cycle counter for an open Wishbone transaction; flags expiry on the
// last allowed cycle. TIMEOUT=0 disables expiry entirely.
module qspis_wb_tmr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] MAXV = (TIMEOUT > 0) ? CW'(TIMEOUT) : '0;

    logic [CW-1:0] r_cnt;

    // Count cycles while enabled, restart on clear, saturate instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != MAXV)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (r_cnt == LAST);

endmodule

// File: rtl/qspis_reg2wb_bridge.sv
// Registered register-to-Wishbone master bridge. One transaction is held open
// until ack, err or timeout, then a single-cycle reg_ack reports the outcome.
// Optional feature macro: QSPIS_WB_POSTED_WR_EN (posted writes with a sticky
// background error flag wb_post_err).
module qspis_reg2wb_bridge
    import qspis_wb_pkg::*;
#(
    parameter int                DW        = 32,
    parameter int                AW_IN     = 24,
    parameter int                AW_OUT    = 32,
    parameter logic [AW_OUT-1:0] ADDR_BASE = '0,
    parameter int                TIMEOUT   = 255,
    parameter logic [31:0]       TO_RDATA  = TO_RDATA_DEFAULT
) (
    input  logic                      mclk,
    input  logic                      rst_n,
    input  logic                      reg_wr,
    input  logic                      reg_rd,
    input  logic [AW_IN-1:0]          reg_addr,
    input  logic [beWidth(DW)-1:0]    reg_be,
    input  logic [DW-1:0]             reg_wdata,
    output logic [DW-1:0]             reg_rdata,
    output logic                      reg_ack,
    output logic                      reg_err,
    output logic                      reg_tmo,
    output logic                      wbm_cyc_o,
    output logic                      wbm_stb_o,
    output logic [AW_OUT-1:0]         wbm_adr_o,
    output logic                      wbm_we_o,
    output logic [DW-1:0]             wbm_dat_o,
    output logic [beWidth(DW)-1:0]    wbm_sel_o,
    input  logic [DW-1:0]             wbm_dat_i,
    input  logic                      wbm_ack_i,
    input  logic                      wbm_err_i,
    output logic                      wb_post_err,
    input  logic                      wb_err_clr
);

    localparam int            BW    = beWidth(DW);
    localparam logic [DW-1:0] LP_TO = DW'(TO_RDATA);

    state_t           r_state, w_state;
    logic             r_cyc, w_cyc;
    logic             r_we, w_we;
    logic [AW_IN-1:0] r_adr, w_adr;
    logic [DW-1:0]    r_dat, w_dat;
    logic [BW-1:0]    r_sel, w_sel;
    logic [DW-1:0]    r_rdata, w_rdata;
    logic             r_ack, w_ack;
    logic             r_err, w_err;
    logic             r_tmo, w_tmo;
    logic             r_posted, w_posted;
    logic             w_tmr_clr;
    logic             w_tmr_exp;
    logic             w_post_set;

    qspis_wb_tmr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmr (
        .clk     (mclk),
        .rst_n   (rst_n),
        .clr     (w_tmr_clr),
        .en      (r_state == BUSY),
        .expired (w_tmr_exp)
    );

    // Next-state and next-register values: accept in IDLE, resolve in BUSY, report in DONE.
    always_comb begin
        w_state    = r_state;
        w_cyc      = r_cyc;
        w_we       = r_we;
        w_adr      = r_adr;
        w_dat      = r_dat;
        w_sel      = r_sel;
        w_rdata    = r_rdata;
        w_ack      = 1'b0;
        w_err      = 1'b0;
        w_tmo      = 1'b0;
        w_posted   = r_posted;
        w_tmr_clr  = 1'b0;
        w_post_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (reg_wr || reg_rd) begin
                    w_state   = BUSY;
                    w_cyc     = 1'b1;
                    w_we      = reg_wr;
                    w_adr     = reg_addr;
                    w_dat     = reg_wdata;
                    w_sel     = reg_be;
                    w_tmr_clr = 1'b1;
`ifdef QSPIS_WB_POSTED_WR_EN
                    w_posted  = reg_wr;
                    w_ack     = reg_wr;
`else
                    w_posted  = 1'b0;
`endif
                end
            end
            BUSY: begin
                if (wbm_ack_i || wbm_err_i) begin
                    w_cyc = 1'b0;
                    if (r_posted) begin
                        w_state    = IDLE;
                        w_post_set = wbm_err_i;
                    end else begin
                        w_state = DONE;
                        w_ack   = 1'b1;
                        w_err   = wbm_err_i;
                        if (r_we) begin
                            w_rdata = '0;
                        end else if (wbm_err_i) begin
                            w_rdata = LP_TO;
                        end else begin
                            w_rdata = wbm_dat_i;
                        end
                    end
                end else if (w_tmr_exp) begin
                    w_cyc = 1'b0;
                    if (r_posted) begin
                        w_state    = IDLE;
                        w_post_set = 1'b1;
                    end else begin
                        w_state = DONE;
                        w_ack   = 1'b1;
                        w_err   = 1'b1;
                        w_tmo   = 1'b1;
                        w_rdata = LP_TO;
                    end
                end
            end
            DONE: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops cyc at once and suppresses any pending ack.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cyc    <= 1'b0;
            r_we     <= 1'b0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_sel    <= '0;
            r_rdata  <= '0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_tmo    <= 1'b0;
            r_posted <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cyc    <= w_cyc;
            r_we     <= w_we;
            r_adr    <= w_adr;
            r_dat    <= w_dat;
            r_sel    <= w_sel;
            r_rdata  <= w_rdata;
            r_ack    <= w_ack;
            r_err    <= w_err;
            r_tmo    <= w_tmo;
            r_posted <= w_posted;
        end
    end

`ifdef QSPIS_WB_POSTED_WR_EN
    logic r_post_err;

    // Sticky background write error; a new error beats a same-cycle clear.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            r_post_err <= 1'b0;
        end else if (w_post_set) begin
            r_post_err <= 1'b1;
        end else if (wb_err_clr) begin
            r_post_err <= 1'b0;
        end
    end

    assign wb_post_err = r_post_err;
`else
    logic w_unused;
    assign w_unused    = wb_err_clr ^ w_post_set;
    assign wb_post_err = 1'b0;
`endif

    generate
        if (AW_OUT > AW_IN) begin : g_adr_ext
            assign wbm_adr_o = {ADDR_BASE[AW_OUT-1:AW_IN], r_adr};
        end else begin : g_adr_same
            assign wbm_adr_o = r_adr;
        end
    endgenerate

    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbm_we_o  = r_we;
    assign wbm_dat_o = r_dat;
    assign wbm_sel_o = r_sel;
    assign reg_rdata = r_rdata;
    assign reg_ack   = r_ack;
    assign reg_err   = r_err;
    assign reg_tmo   = r_tmo;

endmodule

// File: tb/tb_qspis_reg2wb_bridge.sv
// Directed self-checking bench for qspis_reg2wb_bridge (TIMEOUT=8).
module tb_qspis_reg2wb_bridge;

`ifdef QSPIS_WB_POSTED_WR_EN
    localparam logic POSTED = 1'b1;
`else
    localparam logic POSTED = 1'b0;
`endif

    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_wr = 1'b0;
    logic        reg_rd = 1'b0;
    logic [23:0] reg_addr = '0;
    logic [3:0]  reg_be = '0;
    logic [31:0] reg_wdata = '0;
    logic [31:0] reg_rdata;
    logic        reg_ack, reg_err, reg_tmo;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;
    logic        wb_post_err;
    logic        wb_err_clr = 1'b0;

    int testsRun = 0;
    int testsFailed = 0;

    qspis_reg2wb_bridge #(
        .DW      (32),
        .AW_IN   (24),
        .AW_OUT  (32),
        .TIMEOUT (8)
    ) dut (
        .mclk        (mclk),
        .rst_n       (rst_n),
        .reg_wr      (reg_wr),
        .reg_rd      (reg_rd),
        .reg_addr    (reg_addr),
        .reg_be      (reg_be),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .reg_ack     (reg_ack),
        .reg_err     (reg_err),
        .reg_tmo     (reg_tmo),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_err_i   (wbm_err_i),
        .wb_post_err (wb_post_err),
        .wb_err_clr  (wb_err_clr)
    );

    // Free-running 10-unit clock.
    always #5 mclk = ~mclk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    // Drive the requester side of the register interface.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [23:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata);
        reg_wr    = wr;
        reg_rd    = rd;
        reg_addr  = addr;
        reg_be    = be;
        reg_wdata = wdata;
    endtask

    // Write whose slave acks in the first stb cycle; optionally with reg_rd also raised.
    task automatic writeSingleAck(input string tag, input logic alsoRd, input logic [23:0] addr,
                                  input logic [3:0] be, input logic [31:0] data);
        applyStimulus(1'b1, alsoRd, addr, be, data);
        tick();
        checkOutput({tag, "_cyc1"}, 64'(wbm_cyc_o), 64'd1);
        checkOutput({tag, "_stb1"}, 64'(wbm_stb_o), 64'd1);
        checkOutput({tag, "_we"}, 64'(wbm_we_o), 64'd1);
        checkOutput({tag, "_sel"}, 64'(wbm_sel_o), 64'(be));
        checkOutput({tag, "_dat"}, 64'(wbm_dat_o), 64'(data));
        checkOutput({tag, "_adr"}, 64'(wbm_adr_o), 64'({8'h00, addr}));
        checkOutput({tag, "_ack_c1"}, 64'(reg_ack), 64'(POSTED));
        wbm_ack_i = 1'b1;
        if (POSTED) applyStimulus(1'b0, 1'b0, '0, '0, '0);
        tick();
        wbm_ack_i = 1'b0;
        checkOutput({tag, "_ack_c2"}, 64'(reg_ack), 64'(!POSTED));
        checkOutput({tag, "_err"}, 64'(reg_err), 64'd0);
        checkOutput({tag, "_cyc2"}, 64'(wbm_cyc_o), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        tick();
        checkOutput({tag, "_ack_c3"}, 64'(reg_ack), 64'd0);
        checkOutput({tag, "_cyc3"}, 64'(wbm_cyc_o), 64'd0);
        tick();
        checkOutput({tag, "_cyc4"}, 64'(wbm_cyc_o), 64'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        checkOutput("rst_cyc", 64'(wbm_cyc_o), 64'd0);
        checkOutput("rst_stb", 64'(wbm_stb_o), 64'd0);
        checkOutput("rst_we", 64'(wbm_we_o), 64'd0);
        checkOutput("rst_ack", 64'(reg_ack), 64'd0);
        checkOutput("rst_adr", 64'(wbm_adr_o), 64'd0);
        checkOutput("rst_rdata", 64'(reg_rdata), 64'd0);
        checkOutput("rst_perr", 64'(wb_post_err), 64'd0);
        rst_n = 1'b1;
        tick();

        // Test 1: read, slave acks in cycle 4, reg_ack in cycle 5
        applyStimulus(1'b0, 1'b1, 24'hABCDEF, 4'hF, '0);
        tick();
        checkOutput("t1_cyc", 64'(wbm_cyc_o), 64'd1);
        checkOutput("t1_we", 64'(wbm_we_o), 64'd0);
        checkOutput("t1_adr", 64'(wbm_adr_o), 64'h00AB_CDEF);
        tick();
        tick();
        checkOutput("t1_cyc3", 64'(wbm_cyc_o), 64'd1);
        tick();
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h1234_5678;
        checkOutput("t1_noack4", 64'(reg_ack), 64'd0);
        tick();
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        checkOutput("t1_ack5", 64'(reg_ack), 64'd1);
        checkOutput("t1_rdata", 64'(reg_rdata), 64'h1234_5678);
        checkOutput("t1_err", 64'(reg_err), 64'd0);
        checkOutput("t1_cyc5", 64'(wbm_cyc_o), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        tick();
        checkOutput("t1_ack6", 64'(reg_ack), 64'd0);

        // Test 2: write with byte enables, combinational ack
        writeSingleAck("t2", 1'b0, 24'h000010, 4'b0101, 32'hA5A5_0F0F);

        // Test 3: read with no ack times out after 8 stb cycles
        applyStimulus(1'b0, 1'b1, 24'h000020, 4'hF, '0);
        tick();
        for (int i = 1; i <= 8; i++) begin
            checkOutput($sformatf("t3_cyc%0d", i), 64'(wbm_cyc_o), 64'd1);
            checkOutput($sformatf("t3_noack%0d", i), 64'(reg_ack), 64'd0);
            tick();
        end
        checkOutput("t3_cyc9", 64'(wbm_cyc_o), 64'd0);
        checkOutput("t3_ack", 64'(reg_ack), 64'd1);
        checkOutput("t3_err", 64'(reg_err), 64'd1);
        checkOutput("t3_tmo", 64'(reg_tmo), 64'd1);
        checkOutput("t3_rdata", 64'(reg_rdata), 64'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        checkOutput("t3_late_ack", 64'(reg_ack), 64'd0);
        checkOutput("t3_late_cyc", 64'(wbm_cyc_o), 64'd0);
        tick();
        checkOutput("t3_late_ack2", 64'(reg_ack), 64'd0);

        // Test 4a: slave error on read
        applyStimulus(1'b0, 1'b1, 24'h000030, 4'hF, '0);
        tick();
        wbm_err_i = 1'b1;
        wbm_dat_i = 32'h1111_2222;
        tick();
        wbm_err_i = 1'b0;
        wbm_dat_i = '0;
        checkOutput("t4_ack", 64'(reg_ack), 64'd1);
        checkOutput("t4_err", 64'(reg_err), 64'd1);
        checkOutput("t4_tmo", 64'(reg_tmo), 64'd0);
        checkOutput("t4_rdata", 64'(reg_rdata), 64'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        tick();

        // Test 4b: write and read together gives a single write
        writeSingleAck("t4b", 1'b1, 24'h000044, 4'b1100, 32'h0BAD_F00D);

        // Test 5: reset during BUSY drops cyc without reg_ack
        applyStimulus(1'b0, 1'b1, 24'h000050, 4'hF, '0);
        tick();
        checkOutput("t5_cyc", 64'(wbm_cyc_o), 64'd1);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        tick();
        checkOutput("t5_rst_cyc", 64'(wbm_cyc_o), 64'd0);
        checkOutput("t5_rst_ack", 64'(reg_ack), 64'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("t5_post_ack", 64'(reg_ack), 64'd0);
        applyStimulus(1'b0, 1'b1, 24'h000054, 4'hF, '0);
        tick();
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hCAFE_F00D;
        tick();
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        checkOutput("t5_ack", 64'(reg_ack), 64'd1);
        checkOutput("t5_rdata", 64'(reg_rdata), 64'hCAFE_F00D);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        tick();

`ifdef QSPIS_WB_POSTED_WR_EN
        // Test 6: posted write with slave error, read stalls until the write drains
        applyStimulus(1'b1, 1'b0, 24'h000060, 4'hF, 32'h5555_AAAA);
        tick();
        checkOutput("t6_ack1", 64'(reg_ack), 64'd1);
        checkOutput("t6_err1", 64'(reg_err), 64'd0);
        checkOutput("t6_cyc1", 64'(wbm_cyc_o), 64'd1);
        applyStimulus(1'b0, 1'b1, 24'h000064, 4'hF, '0);
        tick();
        checkOutput("t6_ack2", 64'(reg_ack), 64'd0);
        checkOutput("t6_we2", 64'(wbm_we_o), 64'd1);
        tick();
        wbm_err_i = 1'b1;
        tick();
        wbm_err_i = 1'b0;
        checkOutput("t6_cyc4", 64'(wbm_cyc_o), 64'd0);
        checkOutput("t6_perr", 64'(wb_post_err), 64'd1);
        checkOutput("t6_ack4", 64'(reg_ack), 64'd0);
        tick();
        checkOutput("t6_rd_cyc", 64'(wbm_cyc_o), 64'd1);
        checkOutput("t6_rd_we", 64'(wbm_we_o), 64'd0);
        checkOutput("t6_rd_adr", 64'(wbm_adr_o), 64'h0000_0064);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h7777_8888;
        tick();
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        checkOutput("t6_rd_ack", 64'(reg_ack), 64'd1);
        checkOutput("t6_rd_rdata", 64'(reg_rdata), 64'h7777_8888);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        wb_err_clr = 1'b1;
        tick();
        wb_err_clr = 1'b0;
        checkOutput("t6_clr", 64'(wb_post_err), 64'd0);
`else
        // Test 6 (default build): erroring write is non-posted and leaves wb_post_err low
        applyStimulus(1'b1, 1'b0, 24'h000060, 4'hF, 32'h5555_AAAA);
        tick();
        checkOutput("t6_ack1", 64'(reg_ack), 64'd0);
        wbm_err_i = 1'b1;
        tick();
        wbm_err_i = 1'b0;
        checkOutput("t6_ack2", 64'(reg_ack), 64'd1);
        checkOutput("t6_err2", 64'(reg_err), 64'd1);
        checkOutput("t6_rdata", 64'(reg_rdata), 64'd0);
        checkOutput("t6_perr", 64'(wb_post_err), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        wb_err_clr = 1'b1;
        tick();
        wb_err_clr = 1'b0;
        checkOutput("t6_perr_clr", 64'(wb_post_err), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
